if_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the pipelined ARM core. Owns the PC and drives the address
//  of the combinational, word-addressed (pc>>2), read-only instruction memory. Captures the

---
 rtl/arm_if_pkg.sv | 13 +
 rtl/sat_counter.sv | 31 +++
 rtl/if_fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_if_fetch_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/arm_if_pkg.sv
// rtl/arm_if_pkg.sv - shared types and constants for the instruction-fetch sequencer
package arm_if_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } fetch_state_t;

    localparam logic [31:0] INST_BUBBLE = 32'h0000_0000;
    localparam logic [31:0] PC_STEP     = 32'd4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit event counter that sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - PC owner and IF/ID register with boot, freeze, redirect, halt and fault
module if_fetch_ctrl
    import arm_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter int          MEM_DEPTH   = 64,
    parameter int          BOOT_CYCLES = 2,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [31:0]      branch_addr,
    input  logic             halt_req,
    output logic [31:0]      imem_pc,
    input  logic [31:0]      imem_inst,
    output logic             id_valid,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_inst,
    output logic [1:0]       fetch_state,
    output logic             pc_fault,
    output logic [CNT_W-1:0] fetched_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int BW = (BOOT_CYCLES < 2) ? 1 : $clog2(BOOT_CYCLES + 1);

    fetch_state_t  state_q, state_d;
    logic [BW-1:0] boot_cnt_q, boot_cnt_d;
    logic [31:0]   pc_q, pc_d;
    logic          id_valid_q, id_valid_d;
    logic [31:0]   id_pc_q, id_pc_d;
    logic [31:0]   id_inst_q, id_inst_d;
    logic          pc_fault_q, pc_fault_d;
    logic          fetch_inc;
    logic          stall_inc;
    logic          pc_bad;

    // Only the PC actually being fetched is range-checked; redirect targets are not.
    assign pc_bad = (pc_q[1:0] != 2'b00) || ((pc_q >> 2) >= 32'(MEM_DEPTH));

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        pc_fault_d = pc_fault_q;
        fetch_inc  = 1'b0;
        stall_inc  = 1'b0;

        case (state_q)
            ST_BOOT: begin
                boot_cnt_d = boot_cnt_q - BW'(1);
                if (boot_cnt_q == BW'(1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (branch_taken) begin
                    pc_d       = branch_addr;
                    id_valid_d = 1'b0;
                    id_inst_d  = INST_BUBBLE;
                end else if (pc_bad) begin
                    pc_fault_d = 1'b1;
                    state_d    = ST_HALT;
                    id_valid_d = 1'b0;
                    id_inst_d  = INST_BUBBLE;
                end else if (halt_req) begin
                    state_d    = ST_HALT;
                    id_valid_d = 1'b0;
                    id_inst_d  = INST_BUBBLE;
                end else if (freeze) begin
                    stall_inc = 1'b1;
                end else begin
                    id_inst_d  = imem_inst;
                    id_pc_d    = pc_q + PC_STEP;
                    id_valid_d = 1'b1;
                    pc_d       = pc_q + PC_STEP;
                    fetch_inc  = 1'b1;
                end
            end
            ST_HALT: begin
                if (!halt_req && !pc_fault_q) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= BW'(BOOT_CYCLES);
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'h0;
            id_inst_q  <= INST_BUBBLE;
            pc_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            pc_fault_q <= pc_fault_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_fetched_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (fetch_inc),
        .count (fetched_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    assign imem_pc     = pc_q;
    assign id_valid    = id_valid_q;
    assign id_pc       = id_pc_q;
    assign id_inst     = id_inst_q;
    assign fetch_state = state_q;
    assign pc_fault    = pc_fault_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             freeze;
    logic             branch_taken;
    logic [31:0]      branch_addr;
    logic             halt_req;
    logic [31:0]      imem_pc;
    logic [31:0]      imem_inst;
    logic             id_valid;
    logic [31:0]      id_pc;
    logic [31:0]      id_inst;
    logic [1:0]       fetch_state;
    logic             pc_fault;
    logic [CNT_W-1:0] fetched_cnt;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks;
    int n_fail;

    if_fetch_ctrl #(
        .RESET_PC    (32'h0),
        .MEM_DEPTH   (64),
        .BOOT_CYCLES (2),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .halt_req     (halt_req),
        .imem_pc      (imem_pc),
        .imem_inst    (imem_inst),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .fetch_state  (fetch_state),
        .pc_fault     (pc_fault),
        .fetched_cnt  (fetched_cnt),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory stand-in: word content tagged with its own byte address.
    assign imem_inst = {16'hA5A5, imem_pc[15:0]};

    function automatic logic [31:0] inst_at(input logic [31:0] addr);
        return {16'hA5A5, addr[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        halt_req     = 1'b0;
        rst_n        = 1'b0;
        tick(1);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // 1: reset values, boot window, first three fetches
        do_reset();
        check_eq("rst_pc",      imem_pc, 32'h0);
        check_eq("rst_state",   32'(fetch_state), 32'd0);
        check_eq("rst_valid",   32'(id_valid), 32'd0);
        check_eq("rst_idpc",    id_pc, 32'h0);
        check_eq("rst_inst",    id_inst, 32'h0);
        check_eq("rst_fault",   32'(pc_fault), 32'd0);
        check_eq("rst_fetched", 32'(fetched_cnt), 32'd0);
        check_eq("rst_stall",   32'(stall_cnt), 32'd0);
        tick(1);
        check_eq("boot1_state", 32'(fetch_state), 32'd0);
        check_eq("boot1_pc",    imem_pc, 32'h0);
        tick(1);
        check_eq("boot2_state", 32'(fetch_state), 32'd1);
        check_eq("boot2_pc",    imem_pc, 32'h0);
        check_eq("boot2_valid", 32'(id_valid), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            check_eq("run_idpc",  id_pc, 32'(4 * k));
            check_eq("run_valid", 32'(id_valid), 32'd1);
            check_eq("run_inst",  id_inst, inst_at(32'(4 * (k - 1))));
        end
        check_eq("run_fetched3", 32'(fetched_cnt), 32'd3);

        // 2: freeze holds PC and IF/ID
        tick(1);
        check_eq("pre_frz_pc", imem_pc, 32'd16);
        freeze = 1'b1;
        tick(3);
        check_eq("frz_pc",    imem_pc, 32'd16);
        check_eq("frz_idpc",  id_pc, 32'd16);
        check_eq("frz_inst",  id_inst, inst_at(32'd12));
        check_eq("frz_valid", 32'(id_valid), 32'd1);
        check_eq("frz_stall", 32'(stall_cnt), 32'd3);
        freeze = 1'b0;
        tick(1);
        check_eq("unfrz_idpc", id_pc, 32'd20);
        check_eq("unfrz_inst", id_inst, inst_at(32'd16));

        // 3: branch wins over freeze, one bubble
        branch_taken = 1'b1;
        freeze       = 1'b1;
        branch_addr  = 32'h90;
        tick(1);
        branch_taken = 1'b0;
        freeze       = 1'b0;
        check_eq("br_pc",    imem_pc, 32'h90);
        check_eq("br_valid", 32'(id_valid), 32'd0);
        check_eq("br_inst",  id_inst, 32'h0);
        check_eq("br_stall", 32'(stall_cnt), 32'd3);
        tick(1);
        check_eq("br_tgt_idpc",  id_pc, 32'h94);
        check_eq("br_tgt_valid", 32'(id_valid), 32'd1);
        check_eq("br_tgt_inst",  id_inst, inst_at(32'h90));
        check_eq("br_fetched",   32'(fetched_cnt), 32'd6);

        // 4: out-of-range target faults, sticky until reset
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        tick(1);
        branch_taken = 1'b0;
        check_eq("oor_pc",        imem_pc, 32'h100);
        check_eq("oor_fault_pre", 32'(pc_fault), 32'd0);
        tick(1);
        check_eq("oor_fault", 32'(pc_fault), 32'd1);
        check_eq("oor_state", 32'(fetch_state), 32'd2);
        check_eq("oor_valid", 32'(id_valid), 32'd0);
        tick(2);
        check_eq("oor_stuck", 32'(fetch_state), 32'd2);
        check_eq("oor_hold",  imem_pc, 32'h100);
        rst_n = 1'b0;
        #1;
        check_eq("async_fault_clr", 32'(pc_fault), 32'd0);
        check_eq("async_state",     32'(fetch_state), 32'd0);
        tick(1);
        rst_n = 1'b1;

        // 5: misaligned target
        tick(3);
        check_eq("mis_start_pc", imem_pc, 32'h4);
        branch_taken = 1'b1;
        branch_addr  = 32'h22;
        tick(1);
        branch_taken = 1'b0;
        check_eq("mis_pc",        imem_pc, 32'h22);
        check_eq("mis_fault_pre", 32'(pc_fault), 32'd0);
        tick(1);
        check_eq("mis_fault", 32'(pc_fault), 32'd1);
        check_eq("mis_state", 32'(fetch_state), 32'd2);

        // 6: halt/resume, then counter saturation at 4 bits
        do_reset();
        tick(2);
        tick(10);
        check_eq("hlt_start_pc", imem_pc, 32'd40);
        halt_req = 1'b1;
        tick(1);
        check_eq("hlt_state", 32'(fetch_state), 32'd2);
        check_eq("hlt_valid", 32'(id_valid), 32'd0);
        freeze = 1'b1;
        tick(3);
        freeze = 1'b0;
        check_eq("hlt_pc",    imem_pc, 32'd40);
        check_eq("hlt_stall", 32'(stall_cnt), 32'd0);
        halt_req = 1'b0;
        tick(1);
        check_eq("res_state", 32'(fetch_state), 32'd1);
        check_eq("res_pc",    imem_pc, 32'd40);
        tick(1);
        check_eq("res_idpc",    id_pc, 32'd44);
        check_eq("res_valid",   32'(id_valid), 32'd1);
        check_eq("res_fetched", 32'(fetched_cnt), 32'd11);
        tick(9);
        check_eq("sat_pc",      imem_pc, 32'd80);
        check_eq("sat_fetched", 32'(fetched_cnt), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
